// File: rtl/clk_divider_prog.sv
// Programmable clock divider with glitch-free divisor reload at period boundaries.
// Optional sticky invalid-divisor flag enabled by defining CLKDIV_ERR_EN.
module clk_divider_prog #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DEF_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             div_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             running
`ifdef CLKDIV_ERR_EN
  ,
  output logic             div_err
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  logic             accept;
  logic             val_low;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] half;

  assign accept  = div_load && !pend_q;
  assign val_low = (div_val < CNT_W'(2));

  // Next count wraps at N-1; the high phase lasts ceil(N/2) counts.
  assign cnt_next = (cnt_q == div_q - CNT_W'(1)) ? '0 : cnt_q + CNT_W'(1);
  assign half     = (div_q >> 1) + {{(CNT_W-1){1'b0}}, div_q[0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= CNT_W'(DEF_DIV);
      shadow_q <= CNT_W'(DEF_DIV);
      pend_q   <= 1'b0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    clk_d    = clk_q;
    tick_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = RUN;
          cnt_d   = '0;
          clk_d   = 1'b1;
          tick_d  = 1'b1;
          if (pend_q) begin
            div_d  = shadow_q;
            pend_d = 1'b0;
          end
        end else begin
          cnt_d = '0;
          clk_d = 1'b0;
        end
      end
      RUN: begin
        if (en) begin
          cnt_d  = cnt_next;
          tick_d = (cnt_next == '0);
          clk_d  = (cnt_next < half);
          // The new divisor only ever governs a period that starts on this edge.
          if ((cnt_next == '0) && pend_q) begin
            div_d  = shadow_q;
            pend_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Accept is impossible while a load is pending, so it never collides with the apply above.
    if (accept) begin
      shadow_d = val_low ? CNT_W'(2) : div_val;
      pend_d   = 1'b1;
    end
  end

`ifdef CLKDIV_ERR_EN
  logic err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (accept && val_low) begin
      err_q <= 1'b1;
    end
  end

  assign div_err = err_q;
`endif

  assign div_ready = !pend_q;
  assign clk_out   = clk_q;
  assign tick      = tick_q;
  assign running   = (state_q == RUN);

endmodule

// File: doc/clk_divider_prog.md
CLK_DIVIDER_PROG -- requirements
Module: clk_divider_prog

Interface
REQ-001 Parameter CNT_W, default 8: width of divisor and counter.
REQ-002 Parameter DEF_DIV, default 4: divisor active after reset; SHALL be 2..2^CNT_W-1.
REQ-003 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 en  input  1  run/pause control.
REQ-006 div_val  input  CNT_W  requested divisor N.
REQ-007 div_load  input  1  load request; transfer occurs when div_load and div_ready are both high on an edge.
REQ-008 div_ready  output  1  high when no divisor load is pending.
REQ-009 clk_out  output  1  divided clock, registered.
REQ-010 tick  output  1  one-cycle pulse at each period start, registered.
REQ-011 running  output  1  high in state RUN.
REQ-012 div_err  output  1  sticky invalid-divisor flag; present only with CLKDIV_ERR_EN.

Function
REQ-013 State machine SHALL have two states: IDLE and RUN; reset enters IDLE.
REQ-014 IDLE, en=1: apply pending divisor if any, cnt<=0, clk_out<=1, tick<=1, go RUN.
REQ-015 IDLE, en=0: cnt, clk_out and tick SHALL stay 0.
REQ-016 RUN, en=1: next=(cnt==N-1)?0:cnt+1; cnt<=next; tick<=(next==0); clk_out<=(next<ceil(N/2)).
REQ-017 RUN, en=0: pause; cnt and clk_out hold; tick<=0; state stays RUN.
REQ-018 Period SHALL be exactly N enabled cycles; clk_out high ceil(N/2) cycles and low floor(N/2) cycles.
REQ-019 Accepted div_val SHALL go to a shadow register; div_ready<=0 on the following edge.
REQ-020 Shadow SHALL become the active divisor only on a RUN edge where next==0, or on the IDLE->RUN edge; div_ready<=1 on that same edge.
REQ-021 A divisor change SHALL never shorten or stretch the period in progress (glitch-free).
REQ-022 div_load while div_ready=0 SHALL be ignored; the first pending value is kept.
REQ-023 div_val<2 on accept: the shadow SHALL load 2 (clamp).
REQ-024 div_load accepted on the wrap edge SHALL take effect at the next wrap, not the current one.
REQ-025 Counter arithmetic SHALL be CNT_W bits unsigned; cnt never reaches N.

Reset
REQ-026 On reset: state=IDLE, cnt=0, clk_out=0, tick=0, running=0, div_ready=1, div_err=0, active divisor=DEF_DIV, no load pending.
REQ-027 Reset mid-period SHALL truncate the period at once; a pending load SHALL be discarded.

Configuration
REQ-028 Macro CLKDIV_ERR_EN defined: div_err SHALL set on any accepted div_val<2 and clear only on reset.
REQ-029 CLKDIV_ERR_EN undefined: div_err port and its logic SHALL be absent; the clamp still applies.

Verification
REQ-030 Reset, en=1, default N=4: clk_out 1,1,0,0 repeating; tick every 4th cycle starting on the first enabled edge.
REQ-031 Load N=5 mid-period of N=4: current period completes as 4 cycles; next period runs 3 high, 2 low; div_ready low from the accept edge until the wrap edge.
REQ-032 Pause: drop en for 3 cycles at cnt=1, N=6: clk_out and cnt frozen; the period resumes and totals 6 enabled cycles.
REQ-033 Load div_val=0 with CLKDIV_ERR_EN: period becomes 2 (1 high, 1 low); div_err=1 and stays 1 after a later valid load.
REQ-034 Second div_load while a load is pending (N=7 then N=3): only 7 is applied.
REQ-035 Assert reset mid-period with a load pending: all outputs take their reset values in the same cycle; after release, en=1 runs with N=DEF_DIV.
